// File: rtl/large_mul_pkg.sv
// Shared definitions for the large multiplier: default geometry and FSM states.
`timescale 1ns/1ps
package large_mul_pkg;

  localparam int N_BITS_DEF     = 1024;
  localparam int SLICE_DEF      = 32;
  localparam int NUM_SLICES_DEF = N_BITS_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/large_mul_wallace32.sv
// wallace32: combinational X_BITS x Y_BITS partial-product multiplier.
// One shifted copy of x per set bit of y, summed by a pairwise adder tree.
// Y_BITS must be a power of two.
`timescale 1ns/1ps
module wallace32 #(
  parameter int X_BITS = 1024,
  parameter int Y_BITS = 32
) (
  input  logic [X_BITS-1:0]        x,
  input  logic [Y_BITS-1:0]        y,
  output logic [X_BITS+Y_BITS-1:0] p
);

  localparam int PW     = X_BITS + Y_BITS;
  localparam int LEVELS = $clog2(Y_BITS);

  logic [PW-1:0] pp   [Y_BITS];
  logic [PW-1:0] tree [Y_BITS];

  genvar gi;
  generate
    for (gi = 0; gi < Y_BITS; gi++) begin : g_pp
      assign pp[gi] = y[gi] ? (PW'(x) << gi) : '0;
    end
  endgenerate

  // Reduce partial products pairwise; each level halves the live terms.
  always_comb begin
    for (int i = 0; i < Y_BITS; i++) begin
      tree[i] = pp[i];
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int j = 0; j < (Y_BITS >> (lvl + 1)); j++) begin
        tree[j] = tree[2*j] + tree[2*j+1];
      end
    end
    p = tree[0];
  end

endmodule

// File: rtl/large_mul_ctrl.sv
// large_mul_ctrl: sequential N_BITS x N_BITS multiplier. Consumes SLICE bits
// of b per CALC cycle through one wallace32, with a two-stage pipeline
// (partial product register, then shifted accumulate).
// Optional macro LARGE_MUL_EARLY_TERM_EN: stop after the highest nonzero
// slice of b instead of always running all NUM_SLICES slices.
`timescale 1ns/1ps
module large_mul_ctrl
  import large_mul_pkg::*;
#(
  parameter int N_BITS = N_BITS_DEF,
  parameter int SLICE  = SLICE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N_BITS-1:0]   a,
  input  logic [N_BITS-1:0]   b,
  output logic                busy,
  output logic                done,
  output logic [2*N_BITS-1:0] p
);

  localparam int NUM_SLICES = N_BITS / SLICE;
  localparam int KW         = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int PW         = N_BITS + SLICE;
  localparam int AW         = 2 * N_BITS;

  state_t          state_reg, state_next;
  logic [N_BITS-1:0] a_reg, b_reg;
  logic [KW-1:0]   k_reg;
  logic [KW-1:0]   last_reg;
  logic [KW-1:0]   last_next;
  logic [PW-1:0]   prod_reg;
  logic [KW-1:0]   kr_reg;
  logic            v1_reg;
  logic [AW-1:0]   acc_reg;
  logic [AW-1:0]   p_reg;

  logic [SLICE-1:0] y_slice;
  logic [PW-1:0]    pp;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_sum;

  // Current multiplier slice selected by the slice counter.
  assign y_slice = SLICE'(b_reg >> (SLICE * k_reg));

  wallace32 #(
    .X_BITS (N_BITS),
    .Y_BITS (SLICE)
  ) u_wallace (
    .x (a_reg),
    .y (y_slice),
    .p (pp)
  );

  // Stage-2 addend: registered partial product aligned to its slice weight.
  assign addend  = AW'(prod_reg) << (SLICE * kr_reg);
  assign acc_sum = acc_reg + addend;

`ifdef LARGE_MUL_EARLY_TERM_EN
  logic [NUM_SLICES-1:0] slice_nz;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLICES; gi++) begin : g_nz
      assign slice_nz[gi] = |b[gi*SLICE +: SLICE];
    end
  endgenerate

  // Index of the highest nonzero slice of the incoming b (0 when b is zero).
  always_comb begin
    last_next = '0;
    for (int i = 0; i < NUM_SLICES; i++) begin
      if (slice_nz[i]) begin
        last_next = KW'(i);
      end
    end
  end
`else
  assign last_next = KW'(NUM_SLICES - 1);
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and status outputs.
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (k_reg == last_reg) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, slice issue (stage 1), accumulation (stage 2), result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      k_reg    <= '0;
      last_reg <= '0;
      prod_reg <= '0;
      kr_reg   <= '0;
      v1_reg   <= 1'b0;
      acc_reg  <= '0;
      p_reg    <= '0;
    end else begin
      v1_reg <= 1'b0;
      if (v1_reg) begin
        acc_reg <= acc_sum;
      end
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_reg    <= a;
            b_reg    <= b;
            k_reg    <= '0;
            last_reg <= last_next;
            acc_reg  <= '0;
          end
        end
        CALC: begin
          prod_reg <= pp;
          kr_reg   <= k_reg;
          v1_reg   <= 1'b1;
          k_reg    <= k_reg + KW'(1);
        end
        DRAIN: begin
          // The last slice is being accumulated now; publish the full sum.
          p_reg <= acc_sum;
        end
        default: ;
      endcase
    end
  end

  assign p = p_reg;

endmodule

// File: tb/tb_large_mul_ctrl.sv
// Self-checking bench for large_mul_ctrl. Expected products come from plain
// 2N-bit multiplication; expected latency from the slice rule (L+2 edges).
`timescale 1ns/1ps
module tb_large_mul_ctrl;

  localparam int NB = 1024;
  localparam int SL = 32;
  localparam int NS = NB / SL;

  logic            clk;
  logic            rst;
  logic            start;
  logic [NB-1:0]   a;
  logic [NB-1:0]   b;
  logic            busy;
  logic            done;
  logic [2*NB-1:0] p;

  int checks;
  int errors;

  large_mul_ctrl #(
    .N_BITS (NB),
    .SLICE  (SL)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .p     (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product: full-width multiply of zero-extended operands.
  function automatic logic [2*NB-1:0] model_mul(input logic [NB-1:0] x, input logic [NB-1:0] y);
    logic [2*NB-1:0] xx;
    logic [2*NB-1:0] yy;
    xx = {{NB{1'b0}}, x};
    yy = {{NB{1'b0}}, y};
    return xx * yy;
  endfunction

  // Edges from accept to the edge after which done is high.
  function automatic int exp_lat(input logic [NB-1:0] y);
    int l;
    l = NS - 1;
`ifdef LARGE_MUL_EARLY_TERM_EN
    l = 0;
    for (int i = 0; i < NS; i++) begin
      if (((y >> (SL * i)) & {{(NB-SL){1'b0}}, {SL{1'b1}}}) != '0) l = i;
    end
`endif
    return l + 2;
  endfunction

  // Random vector with only the low nsl slices populated.
  function automatic logic [NB-1:0] rand_vec(input int nsl);
    logic [NB-1:0] v;
    v = '0;
    for (int i = 0; i < nsl; i++) v[SL*i +: SL] = $urandom();
    return v;
  endfunction

  // Runs one operation from IDLE; returns observed latency, product and
  // counts of handshake irregularities. Leaves the DUT back in IDLE.
  task automatic run_op(input logic [NB-1:0] op_a, input logic [NB-1:0] op_b,
                        output int lat, output logic [2*NB-1:0] prod,
                        output int bad_hs);
    logic [2*NB-1:0] p_before;
    p_before = p;
    bad_hs   = 0;
    lat      = -1;
    a = op_a; b = op_b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = ~op_a; b = ~op_b;
    if (busy !== 1'b1) bad_hs++;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      if (busy !== 1'b1) bad_hs++;
      if (p !== p_before) bad_hs++;
    end
    prod = p;
    if (busy !== 1'b0) bad_hs++;
    @(posedge clk); #1;
    if (done !== 1'b0) bad_hs++;
    if (p !== prod) bad_hs++;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; start = 1'b1; a = 3; b = 5;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (p !== '0) begin errors++; $display("FAIL reset_p: got low64 %h expected 0", p[63:0]); end
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_first_accept: busy got %b expected 1", busy); end
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = n; break; end
    end
    checks++; if (lat != exp_lat(5)) begin errors++; $display("FAIL reset_op_latency: got %0d expected %0d", lat, exp_lat(5)); end
    checks++; if (p !== 2048'd15) begin errors++; $display("FAIL reset_op_product: got low64 %h expected 15", p[63:0]); end
    $display("op reset-release a=3 b=5 lat=%0d p_low64=%h", lat, p[63:0]);
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [NB-1:0]   va [4];
    logic [NB-1:0]   vb [4];
    logic [2*NB-1:0] prod;
    logic [2*NB-1:0] expp;
    logic [NB-1:0]   one;
    int lat, bad;
    one = 1;
    va[0] = 3;        vb[0] = 5;
    va[1] = '1;       vb[1] = '1;
    va[2] = 1;        vb[2] = one << (NB - 1);
    va[3] = rand_vec(NS); vb[3] = '0;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], lat, prod, bad);
      expp = model_mul(va[i], vb[i]);
      checks++; if (prod !== expp) begin errors++; $display("FAIL directed%0d_product: got low64 %h high64 %h expected low64 %h high64 %h", i, prod[63:0], prod[2*NB-1 -: 64], expp[63:0], expp[2*NB-1 -: 64]); end
      checks++; if (lat != exp_lat(vb[i])) begin errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, exp_lat(vb[i])); end
      checks++; if (bad != 0) begin errors++; $display("FAIL directed%0d_handshake: got %0d irregularities expected 0", i, bad); end
      $display("op directed%0d lat=%0d p_low64=%h", i, lat, prod[63:0]);
    end
  endtask

  task automatic test_random();
    logic [NB-1:0]   ra, rb;
    logic [2*NB-1:0] prod, expp;
    int lat, bad;
    for (int i = 0; i < 6; i++) begin
      ra = rand_vec($urandom_range(1, NS));
      rb = rand_vec($urandom_range(0, NS));
      run_op(ra, rb, lat, prod, bad);
      expp = model_mul(ra, rb);
      checks++; if (prod !== expp) begin errors++; $display("FAIL random%0d_product: got low64 %h expected low64 %h", i, prod[63:0], expp[63:0]); end
      checks++; if (lat != exp_lat(rb)) begin errors++; $display("FAIL random%0d_latency: got %0d expected %0d", i, lat, exp_lat(rb)); end
      checks++; if (bad != 0) begin errors++; $display("FAIL random%0d_handshake: got %0d irregularities expected 0", i, bad); end
      $display("op random%0d lat=%0d p_low64=%h", i, lat, prod[63:0]);
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [NB-1:0]   ra, rb;
    logic [2*NB-1:0] prod, expp;
    int lat, bad, seen;
    a = rand_vec(NS); b = rand_vec(NS); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done: got %b expected 0", done); end
    checks++; if (p !== '0) begin errors++; $display("FAIL midreset_p: got low64 %h expected 0", p[63:0]); end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_quiet: got %0d active cycles expected 0", seen); end
    ra = rand_vec(NS); rb = rand_vec(NS);
    run_op(ra, rb, lat, prod, bad);
    expp = model_mul(ra, rb);
    checks++; if (prod !== expp) begin errors++; $display("FAIL midreset_next_product: got low64 %h expected low64 %h", prod[63:0], expp[63:0]); end
    checks++; if (lat != exp_lat(rb)) begin errors++; $display("FAIL midreset_next_latency: got %0d expected %0d", lat, exp_lat(rb)); end
    $display("op after-midreset lat=%0d p_low64=%h", lat, prod[63:0]);
  endtask

  // start held high: accepts occur at the first edge, then two edges after
  // each done edge (one DONE cycle, then the IDLE accept cycle).
  task automatic test_back_to_back();
    logic [NB-1:0]   cap_a, cap_b;
    logic [2*NB-1:0] expp;
    int nxt, acc_e, done_e, nops;
    logic exp_done, exp_busy;
    nxt = 0; acc_e = -1; done_e = -1; nops = 0;
    cap_a = '0; cap_b = '0;
    start = 1'b1;
    for (int e = 0; e < 300 && nops < 3; e++) begin
      a = rand_vec(NS);
      b = rand_vec($urandom_range(0, NS));
      if (e == nxt) begin
        cap_a = a; cap_b = b; acc_e = e;
        done_e = e + exp_lat(b);
        nxt = done_e + 2;
      end
      @(posedge clk); #1;
      exp_done = (e == done_e);
      exp_busy = (e >= acc_e) && (e < done_e);
      checks++; if (done !== exp_done) begin errors++; $display("FAIL b2b_done_e%0d: got %b expected %b", e, done, exp_done); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL b2b_busy_e%0d: got %b expected %b", e, busy, exp_busy); end
      if (e == done_e) begin
        expp = model_mul(cap_a, cap_b);
        checks++; if (p !== expp) begin errors++; $display("FAIL b2b_product%0d: got low64 %h expected low64 %h", nops, p[63:0], expp[63:0]); end
        $display("op b2b%0d accept_edge=%0d done_edge=%0d p_low64=%h", nops, acc_e, done_e, p[63:0]);
        nops++;
      end
    end
    checks++; if (nops != 3) begin errors++; $display("FAIL b2b_count: got %0d ops expected 3", nops); end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_calc();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
